// File: rtl/mem_access_unit.sv
// Load/store bus initiator for a word-addressed memory with no byte enables.
// Optional `MISALIGN_CHECK_EN makes misaligned half/word accesses return an error.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  inout  wire  [31:0]           mem_data
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, ERRQ} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  st_q, st_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           wdata_q, wdata_d;

  logic        misalign, invalid;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext, merged;

`ifdef MISALIGN_CHECK_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign invalid = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) || (req_we && req_funct3[2]) || misalign;

  assign req_ready        = (state_q == IDLE);
  assign mem_addr         = mem_addr_q;
  assign mem_write_enable = mem_we_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_err         = resp_err_q;
  // Bus is only ours during the single write-strobe cycle.
  assign mem_data         = mem_we_q ? wdata_q : 32'bz;

  always_comb begin
    byte_v = mem_data[{off_q, 3'b000} +: 8];
    half_v = mem_data[{off_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   load_ext = {{24{~f3_q[2] & byte_v[7]}}, byte_v};
      2'b01:   load_ext = {{16{~f3_q[2] & half_v[15]}}, half_v};
      default: load_ext = mem_data;
    endcase
    merged = mem_data;
    if (f3_q[1:0] == 2'b00) merged[{off_q, 3'b000} +: 8]    = wdata_q[7:0];
    else                    merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    st_d         = st_q;
    f3_d         = f3_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        st_d    = req_we;
        f3_d    = req_funct3;
        off_d   = req_addr[1:0];
        wdata_d = req_wdata;
        if (invalid) begin
          // Error response is raised on the accept edge so it lands in n+1.
          state_d      = ERRQ;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
        end else begin
          mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (req_we && (req_funct3[1:0] == 2'b10)) begin
            state_d  = WR;
            mem_we_d = 1'b1;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (st_q) begin
          wdata_d  = merged;
          mem_we_d = 1'b1;
          state_d  = WR;
        end else begin
          resp_rdata_d = load_ext;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      WR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        state_d      = IDLE;
      end
      ERRQ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      st_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      st_q         <= st_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule
